// File: rtl/bsg_activation_pwl.sv
// Three-stage activation unit: ReLU / leaky ReLU pass-through plus programmable
// piecewise-linear sigmoid and tanh with odd/complement symmetry and saturation.
module bsg_activation_pwl #(
    parameter int width_p      = 20,
    parameter int frac_p       = 16,
    parameter int seg_bits_p   = 3,
    parameter int range_int_p  = 2,
    parameter int leak_shift_p = 3,
    parameter int tag_width_p  = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     data_i,
    input  logic [1:0]             mode_i,
    input  logic [tag_width_p-1:0] tag_i,
    input  logic                   cfg_v_i,
    output logic                   cfg_ready_o,
    input  logic                   cfg_tanh_i,
    input  logic [seg_bits_p-1:0]  cfg_seg_i,
    input  logic [width_p-1:0]     cfg_slope_i,
    input  logic [width_p-1:0]     cfg_icept_i,
    output logic                   v_o,
    input  logic                   ready_i,
    output logic [width_p-1:0]     data_o,
    output logic [tag_width_p-1:0] tag_o
);

    localparam int entries_lp  = 2 << seg_bits_p;
    localparam int dom_bits_lp = frac_p + range_int_p;
    localparam int off_bits_lp = dom_bits_lp - seg_bits_p;
    localparam int prod_w_lp   = 2 * width_p;

    localparam logic [width_p-1:0]          one_lp   = width_p'(1) << frac_p;
    localparam logic [width_p-1:0]          min_lp   = {1'b1, {(width_p-1){1'b0}}};
    localparam logic [width_p-1:0]          max_lp   = {1'b0, {(width_p-1){1'b1}}};
    localparam logic signed [prod_w_lp-1:0] one_w_lp = prod_w_lp'(one_lp);

    logic adv;
    logic accept;
    logic s0_v_reg, s1_v_reg, s2_v_reg;

    assign adv         = ~s2_v_reg | ready_i;
    assign ready_o     = adv & ~cfg_v_i;
    assign accept      = v_i & ready_o;
    assign cfg_ready_o = cfg_v_i & ~(s0_v_reg | s1_v_reg | s2_v_reg);

    // Tables: index is {tanh_select, segment}; writes only land on an empty pipeline.
    logic [width_p-1:0] slope_mem [entries_lp];
    logic [width_p-1:0] icept_mem [entries_lp];
    logic [seg_bits_p:0] cfg_addr;
    assign cfg_addr = {cfg_tanh_i, cfg_seg_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < entries_lp; i++) begin
                slope_mem[i] <= '0;
                icept_mem[i] <= '0;
            end
        end else if (cfg_ready_o) begin
            slope_mem[cfg_addr] <= cfg_slope_i;
            icept_mem[cfg_addr] <= cfg_icept_i;
        end
    end

    // S0: magnitude, segment split and table lookup.
    logic [width_p-1:0]  abs_in;
    logic [seg_bits_p:0] rd_addr;
    logic                sat_in;

    always_comb begin
        abs_in = data_i;
        if (data_i == min_lp)
            abs_in = max_lp;
        else if (data_i[width_p-1])
            abs_in = -data_i;
    end

    assign rd_addr = {mode_i[0], abs_in[dom_bits_lp-1 -: seg_bits_p]};
    assign sat_in  = |abs_in[width_p-1:dom_bits_lp];

    logic [width_p-1:0]     s0_slope_reg, s0_icept_reg, s0_off_reg, s0_x_reg;
    logic                   s0_sat_reg;
    logic [1:0]             s0_mode_reg;
    logic [tag_width_p-1:0] s0_tag_reg;

    always_ff @(posedge clk_i) begin
        if (adv) begin
            s0_slope_reg <= slope_mem[rd_addr];
            s0_icept_reg <= icept_mem[rd_addr];
            s0_off_reg   <= width_p'(abs_in[off_bits_lp-1:0]);
            s0_sat_reg   <= sat_in;
            s0_mode_reg  <= mode_i;
            s0_tag_reg   <= tag_i;
            s0_x_reg     <= data_i;
        end
    end

    // S1: slope * offset, rescaled back to Q frac_p.
    logic signed [prod_w_lp-1:0] prod;
    assign prod = prod_w_lp'($signed(s0_slope_reg)) * prod_w_lp'($signed(s0_off_reg));

    logic signed [prod_w_lp-1:0] s1_p_reg;
    logic [width_p-1:0]          s1_icept_reg, s1_x_reg;
    logic                        s1_sat_reg;
    logic [1:0]                  s1_mode_reg;
    logic [tag_width_p-1:0]      s1_tag_reg;

    always_ff @(posedge clk_i) begin
        if (adv) begin
            s1_p_reg     <= prod >>> frac_p;
            s1_icept_reg <= s0_icept_reg;
            s1_sat_reg   <= s0_sat_reg;
            s1_mode_reg  <= s0_mode_reg;
            s1_tag_reg   <= s0_tag_reg;
            s1_x_reg     <= s0_x_reg;
        end
    end

    // S2: add, clamp to [0, 1.0], then apply the sign rule of the selected function.
    logic signed [prod_w_lp-1:0] sum;
    logic [width_p-1:0]          r_mag;
    logic [width_p-1:0]          leak;
    logic [width_p-1:0]          res_next;
    logic                        neg;

    assign sum  = prod_w_lp'($signed(s1_icept_reg)) + s1_p_reg;
    assign leak = $signed(s1_x_reg) >>> leak_shift_p;
    assign neg  = s1_x_reg[width_p-1];

    always_comb begin
        r_mag = sum[width_p-1:0];
        if (s1_sat_reg)
            r_mag = one_lp;
        else if (sum[prod_w_lp-1])
            r_mag = '0;
        else if (sum > one_w_lp)
            r_mag = one_lp;
    end

    always_comb begin
        res_next = s1_x_reg;
        case (s1_mode_reg)
            2'd0:    res_next = neg ? '0 : s1_x_reg;
            2'd1:    res_next = neg ? leak : s1_x_reg;
            2'd2:    res_next = neg ? one_lp - r_mag : r_mag;
            default: res_next = neg ? -r_mag : r_mag;
        endcase
    end

    logic [width_p-1:0]     s2_data_reg;
    logic [tag_width_p-1:0] s2_tag_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s0_v_reg    <= 1'b0;
            s1_v_reg    <= 1'b0;
            s2_v_reg    <= 1'b0;
            s2_data_reg <= '0;
            s2_tag_reg  <= '0;
        end else if (adv) begin
            s0_v_reg    <= accept;
            s1_v_reg    <= s0_v_reg;
            s2_v_reg    <= s1_v_reg;
            s2_data_reg <= s1_v_reg ? res_next : '0;
            s2_tag_reg  <= s1_v_reg ? s1_tag_reg : '0;
        end
    end

    assign v_o    = s2_v_reg;
    assign data_o = s2_data_reg;
    assign tag_o  = s2_tag_reg;

endmodule

// File: tb/tb_bsg_activation_pwl.sv
// Randomized and directed bench for bsg_activation_pwl; expected results come from
// an arithmetic model of the activation functions with its own copy of the tables.
module tb_bsg_activation_pwl;

    logic        clk_i = 1'b0;
    logic        reset_i, v_i, ready_o, cfg_v_i, cfg_ready_o, cfg_tanh_i, v_o, ready_i;
    logic [19:0] data_i, cfg_slope_i, cfg_icept_i, data_o;
    logic [1:0]  mode_i;
    logic [3:0]  tag_i, tag_o;
    logic [2:0]  cfg_seg_i;

    bsg_activation_pwl dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .data_i(data_i), .mode_i(mode_i), .tag_i(tag_i),
        .cfg_v_i(cfg_v_i), .cfg_ready_o(cfg_ready_o), .cfg_tanh_i(cfg_tanh_i),
        .cfg_seg_i(cfg_seg_i), .cfg_slope_i(cfg_slope_i), .cfg_icept_i(cfg_icept_i),
        .v_o(v_o), .ready_i(ready_i), .data_o(data_o), .tag_o(tag_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_out = 0;
    bit acc_seen, cfg_seen;
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    logic [19:0] m_slope[16];
    logic [19:0] m_icept[16];

    // Reference: table entries are real-valued line segments over |x| in Q16.
    function automatic logic [19:0] model(input logic [19:0] x, input logic [1:0] mode);
        longint xs, a, sl, ic, pr, r, res;
        int idx;
        xs = longint'($signed(x));
        a  = (xs < 0) ? -xs : xs;
        if (a > 524287) a = 524287;
        if (mode == 2'd0) begin
            res = (xs < 0) ? 0 : xs;
        end else if (mode == 2'd1) begin
            res = (xs < 0) ? -((-xs + 7) / 8) : xs;
        end else begin
            if (a >= 262144) begin
                r = 65536;
            end else begin
                idx = (mode == 2'd3 ? 8 : 0) + int'(a / 32768);
                sl  = longint'($signed(m_slope[idx]));
                ic  = longint'($signed(m_icept[idx]));
                pr  = sl * (a % 32768);
                pr  = (pr >= 0) ? pr / 65536 : -((-pr + 65535) / 65536);
                r   = ic + pr;
                if (r < 0) r = 0;
                if (r > 65536) r = 65536;
            end
            if (xs < 0) res = (mode == 2'd2) ? 65536 - r : -r;
            else        res = r;
        end
        return res[19:0];
    endfunction

    function automatic logic [19:0] rand_x();
        if ($urandom_range(0, 1) == 1) return 20'($urandom);
        return 20'($urandom_range(0, 32'h7FFFF) - 32'h40000);
    endfunction

    // One clock: record handshakes at the falling edge, return 1 ns after the rising edge.
    task automatic tick();
        @(negedge clk_i);
        acc_seen = 0;
        cfg_seen = 0;
        if (v_i && ready_o) begin
            exp_q.push_back({tag_i, model(data_i, mode_i)});
            n_acc++;
            acc_seen = 1;
        end
        if (cfg_ready_o) begin
            m_slope[{cfg_tanh_i, cfg_seg_i}] = cfg_slope_i;
            m_icept[{cfg_tanh_i, cfg_seg_i}] = cfg_icept_i;
            cfg_seen = 1;
        end
        if (v_o && ready_i) begin
            got_q.push_back({tag_o, data_o});
            n_out++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m_slope[i] = '0;
            m_icept[i] = '0;
        end
        exp_q.delete();
        got_q.delete();
        n_acc = 0;
        n_out = 0;
    endtask

    task automatic send(input logic [19:0] x, input logic [1:0] m, input logic [3:0] t);
        v_i = 1'b1; data_i = x; mode_i = m; tag_i = t;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc_seen) break;
        end
        v_i = 1'b0;
    endtask

    task automatic drain();
        v_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 40 && n_out != n_acc; i++) tick();
    endtask

    task automatic write_cfg(input bit th, input logic [2:0] seg, input logic [19:0] sl, input logic [19:0] ic);
        cfg_v_i = 1'b1; cfg_tanh_i = th; cfg_seg_i = seg; cfg_slope_i = sl; cfg_icept_i = ic;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cfg_seen) break;
        end
        cfg_v_i = 1'b0;
        checks++;
        if (!cfg_seen) begin
            errors++;
            $display("FAIL cfg_write_timeout: got no cfg_ready_o, want it within 40 cycles");
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b0; cfg_v_i = 1'b0; ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0; ready_i = 1'b1;
        clear_model();
        #1;
        checks++; if (v_o !== 1'b0)     begin errors++; $display("FAIL reset_v_o: got %b want 0", v_o); end
        checks++; if (data_o !== 20'h0) begin errors++; $display("FAIL reset_data_o: got %h want 00000", data_o); end
        checks++; if (tag_o !== 4'h0)   begin errors++; $display("FAIL reset_tag_o: got %h want 0", tag_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_o: got %b want 1", ready_o); end
        checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready_idle: got %b want 0", cfg_ready_o); end
        cfg_v_i = 1'b1;
        #1;
        checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready_req: got %b want 1", cfg_ready_o); end
        checks++; if (ready_o !== 1'b0)     begin errors++; $display("FAIL reset_ready_cfg: got %b want 0", ready_o); end
        cfg_v_i = 1'b0;
        // Fresh tanh table gives zero; result appears on the third edge after it is offered.
        send(20'h04000, 2'd3, 4'd1);
        tick();
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL latency_early: got v_o=%b want 0", v_o); end
        tick();
        checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL latency: got v_o=%b want 1", v_o); end
        checks++; if ({tag_o, data_o} !== {4'd1, 20'h00000}) begin
            errors++; $display("FAIL fresh_tanh: got %h/%h want 1/00000", tag_o, data_o);
        end
        drain();
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL fresh_count: got %0d want 1", got_q.size()); end
    endtask

    task automatic test_relu();
        logic [23:0] want[3];
        want = '{{4'd2, 20'h00000}, {4'd3, 20'hFE000}, {4'd4, 20'h0C000}};
        exp_q.delete(); got_q.delete();
        send(20'hF8000, 2'd0, 4'd2);
        send(20'hF0000, 2'd1, 4'd3);
        send(20'h0C000, 2'd1, 4'd4);
        checks++; if (v_o !== 1'b1 || data_o !== 20'h00000) begin
            errors++; $display("FAIL relu_latency: got v_o=%b data=%h want 1/00000", v_o, data_o);
        end
        drain();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL relu_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin errors++; $display("FAIL relu[%0d]: got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_sigmoid();
        logic [23:0] want[2];
        want = '{{4'd5, 20'h09000}, {4'd6, 20'h07000}};
        exp_q.delete(); got_q.delete();
        write_cfg(1'b0, 3'd0, 20'h04000, 20'h08000);
        send(20'h04000, 2'd2, 4'd5);
        send(20'hFC000, 2'd2, 4'd6);
        drain();
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL sigmoid_count: got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin errors++; $display("FAIL sigmoid[%0d]: got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_tanh_sat();
        logic [23:0] want[3];
        want = '{{4'd7, 20'h10000}, {4'd8, 20'hF0000}, {4'd9, 20'hF0000}};
        exp_q.delete(); got_q.delete();
        send(20'h50000, 2'd3, 4'd7);
        send(20'hB0000, 2'd3, 4'd8);
        send(20'h80000, 2'd3, 4'd9);
        drain();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL tanh_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin errors++; $display("FAIL tanh[%0d]: got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] xs[6];
        logic [1:0]  ms[6];
        logic [19:0] held_d;
        logic [3:0]  held_t;
        bit          stalled_prev;
        int          k;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 6; i++) begin
            xs[i] = rand_x();
            ms[i] = 2'($urandom);
        end
        k = 0;
        stalled_prev = 0;
        for (int c = 0; c < 80 && (k < 6 || n_out != n_acc); c++) begin
            ready_i = (c >= 3 && c < 8) ? 1'b0 : 1'b1;
            v_i = (k < 6);
            if (k < 6) begin data_i = xs[k]; mode_i = ms[k]; tag_i = 4'(k); end
            #1;
            if (stalled_prev) begin
                checks++;
                if (data_o !== held_d || tag_o !== held_t) begin
                    errors++; $display("FAIL stall_hold: got %h/%h want %h/%h", tag_o, data_o, held_t, held_d);
                end
            end
            if (v_o && !ready_i) begin
                checks++;
                if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready_o: got %b want 0", ready_o); end
            end
            stalled_prev = v_o && !ready_i;
            held_d = data_o;
            held_t = tag_o;
            tick();
            if (acc_seen) k++;
        end
        v_i = 1'b0;
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i][23:20] !== 4'(i)) begin errors++; $display("FAIL b2b_order[%0d]: got tag %h want %h", i, got_q[i][23:20], 4'(i)); end
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_cfg_priority();
        logic [23:0] want[3];
        want = '{{4'd10, 20'h09000}, {4'd11, 20'h07000}, {4'd12, 20'h02000}};
        write_cfg(1'b0, 3'd0, 20'h04000, 20'h08000);
        exp_q.delete(); got_q.delete(); n_acc = 0; n_out = 0;
        send(20'h04000, 2'd2, 4'd10);
        send(20'hFC000, 2'd2, 4'd11);
        cfg_v_i = 1'b1; cfg_tanh_i = 1'b0; cfg_seg_i = 3'd0; cfg_slope_i = 20'h0; cfg_icept_i = 20'h02000;
        v_i = 1'b1; data_i = 20'h04000; mode_i = 2'd2; tag_i = 4'd12;
        cfg_seen = 0;
        for (int c = 0; c < 20 && !cfg_seen; c++) begin
            #1;
            checks++;
            if (ready_o !== 1'b0) begin errors++; $display("FAIL cfg_prio_ready_o: got %b want 0", ready_o); end
            checks++;
            if (cfg_ready_o !== (n_acc == n_out)) begin
                errors++; $display("FAIL cfg_ready_timing: got %b want %b", cfg_ready_o, (n_acc == n_out));
            end
            tick();
        end
        cfg_v_i = 1'b0;
        checks++; if (!cfg_seen) begin errors++; $display("FAIL cfg_prio_timeout: got no write, want one"); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc_seen) break;
        end
        drain();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL cfg_prio_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin errors++; $display("FAIL cfg_prio[%0d]: got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_random();
        exp_q.delete(); got_q.delete(); n_acc = 0; n_out = 0;
        for (int e = 0; e < 16; e++)
            write_cfg(e >= 8, 3'(e), 20'($urandom), 20'($urandom_range(0, 32'h20000) - 32'h8000));
        v_i = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!cfg_v_i && $urandom_range(0, 15) == 0) begin
                cfg_v_i = 1'b1; cfg_tanh_i = 1'($urandom); cfg_seg_i = 3'($urandom);
                cfg_slope_i = 20'($urandom); cfg_icept_i = 20'($urandom_range(0, 32'h20000) - 32'h8000);
            end
            if (!v_i) begin
                v_i = ($urandom_range(0, 3) != 0); data_i = rand_x(); mode_i = 2'($urandom); tag_i = 4'($urandom);
            end
            ready_i = ($urandom_range(0, 3) != 0);
            tick();
            if (acc_seen) v_i = 1'b0;
            if (cfg_seen) cfg_v_i = 1'b0;
        end
        v_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 40 && cfg_v_i; i++) begin
            tick();
            if (cfg_seen) cfg_v_i = 1'b0;
        end
        cfg_v_i = 1'b0;
        drain();
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] want[3];
        want = '{{4'd1, 20'h00000}, {4'd2, 20'h00000}, {4'd3, 20'h10000}};
        exp_q.delete(); got_q.delete(); n_acc = 0; n_out = 0;
        send(20'h04000, 2'd2, 4'd13);
        send(20'h2C000, 2'd3, 4'd14);
        send(20'hEC000, 2'd2, 4'd15);
        reset_i = 1'b1; ready_i = 1'b0; v_i = 1'b0;
        tick();
        checks++; if (v_o !== 1'b0)     begin errors++; $display("FAIL midreset_v_o: got %b want 0", v_o); end
        checks++; if (data_o !== 20'h0) begin errors++; $display("FAIL midreset_data_o: got %h want 00000", data_o); end
        reset_i = 1'b0; ready_i = 1'b1;
        clear_model();
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (v_o !== 1'b0) begin errors++; $display("FAIL stale_output[%0d]: got v_o=%b tag %h want 0", c, v_o, tag_o); end
        end
        send(20'h04000, 2'd2, 4'd1);
        send(20'h2C000, 2'd3, 4'd2);
        send(20'hEC000, 2'd2, 4'd3);
        drain();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL midreset_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin errors++; $display("FAIL zero_table[%0d]: got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; cfg_v_i = 1'b0; ready_i = 1'b0;
        data_i = '0; mode_i = '0; tag_i = '0;
        cfg_tanh_i = 1'b0; cfg_seg_i = '0; cfg_slope_i = '0; cfg_icept_i = '0;
        test_reset();
        test_relu();
        test_sigmoid();
        test_tanh_sat();
        test_back_to_back();
        test_cfg_priority();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
